// File: rtl/qrs_decision.sv
// Adaptive-threshold QRS decision stage: classifies detector peaks, tracks SPKI/NPKI and reports RR.
// Optional searchback for missed beats is enabled with the QRS_SEARCHBACK_EN macro.
module qrs_decision #(
    parameter int DATA_WIDTH    = 16,
    parameter int LEARN_LEN     = 400,
    parameter int REFRACTORY    = 40,
    parameter int RR_WIDTH      = 12,
    parameter int RR_MISS_LIMIT = 332
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] peak_in,
    input  logic                         peak_flag,
    output logic                         timer_activation,
    output logic                         qrs_flag,
    output logic                         sb_flag,
    output logic [RR_WIDTH-1:0]          rr_interval,
    output logic [DATA_WIDTH-1:0]        threshold1
);
    localparam int LW  = DATA_WIDTH + 1;
    localparam int LCW = $clog2(LEARN_LEN + 1);
    localparam int RCW = $clog2(REFRACTORY + 1);

    typedef enum logic [1:0] {ST_LEARN, ST_DETECT, ST_REFRACT} state_t;

    state_t                state_r, state_n;
    logic signed [LW-1:0]  spki_r, spki_n, npki_r, npki_n, max_pk_r, max_pk_n;
    logic [LCW-1:0]        learn_cnt_r, learn_cnt_n;
    logic [RCW-1:0]        ref_cnt_r, ref_cnt_n;
    logic [RR_WIDTH-1:0]   rr_cnt_r, rr_cnt_n, rr_int_r, rr_int_n, rr_inc_s;
    logic                  qrs_r, qrs_n, timer_r, timer_n;
    logic signed [LW-1:0]  p_s, diff_s, thr1_s, spki_upd_s, npki_upd_s, sb_spki_s;
    logic                  qrs_det_s, noise_s, sb_hit_s;
    logic [RR_WIDTH-1:0]   sb_pos_s;

    // Rectified peak, thresholds and the 1/8 running-average updates
    assign p_s        = peak_in[DATA_WIDTH-1] ? {LW{1'b0}} : {1'b0, peak_in};
    assign diff_s     = spki_r - npki_r;
    assign thr1_s     = npki_r + (diff_s >>> 2);
    assign spki_upd_s = spki_r - (spki_r >>> 3) + (p_s >>> 3);
    assign npki_upd_s = npki_r - (npki_r >>> 3) + (p_s >>> 3);
    assign rr_inc_s   = (&rr_cnt_r) ? rr_cnt_r : rr_cnt_r + {{(RR_WIDTH-1){1'b0}}, 1'b1};
    assign qrs_det_s  = en && (state_r == ST_DETECT) && peak_flag && (p_s > thr1_s);
    assign noise_s    = en && (state_r == ST_DETECT) && peak_flag && !(p_s > thr1_s);

`ifdef QRS_SEARCHBACK_EN
    logic signed [LW-1:0]  sb_pk_r, thr2_s;
    logic [RR_WIDTH-1:0]   sb_pos_r;
    logic                  sb_r;

    assign thr2_s    = thr1_s >>> 1;
    assign sb_hit_s  = en && (state_r == ST_DETECT) && !qrs_det_s &&
                       (rr_cnt_r >= RR_WIDTH'(RR_MISS_LIMIT)) && (sb_pk_r > thr2_s);
    assign sb_spki_s = spki_r - (spki_r >>> 2) + (sb_pk_r >>> 2);
    assign sb_pos_s  = sb_pos_r;
    assign sb_flag   = sb_r & en;

    // Largest noise peak since the last QRS and its position, plus the searchback pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sb_pk_r  <= {LW{1'b0}};
            sb_pos_r <= {RR_WIDTH{1'b0}};
            sb_r     <= 1'b0;
        end else if (en) begin
            sb_r <= sb_hit_s;
            if (qrs_det_s || sb_hit_s) begin
                sb_pk_r  <= {LW{1'b0}};
                sb_pos_r <= {RR_WIDTH{1'b0}};
            end else if (noise_s && (p_s > sb_pk_r)) begin
                sb_pk_r  <= p_s;
                sb_pos_r <= rr_cnt_r;
            end else begin
                sb_pk_r  <= sb_pk_r;
                sb_pos_r <= sb_pos_r;
            end
        end else begin
            sb_r <= sb_r;
        end
    end
`else
    assign sb_hit_s  = 1'b0;
    assign sb_spki_s = spki_r;
    assign sb_pos_s  = {RR_WIDTH{1'b0}};
    assign sb_flag   = 1'b0;
`endif

    // Next-state logic; every register holds while en is low
    always_comb begin
        state_n     = state_r;
        spki_n      = spki_r;
        npki_n      = npki_r;
        max_pk_n    = max_pk_r;
        learn_cnt_n = learn_cnt_r;
        ref_cnt_n   = ref_cnt_r;
        rr_cnt_n    = rr_cnt_r;
        rr_int_n    = rr_int_r;
        qrs_n       = qrs_r;
        timer_n     = timer_r;
        if (en) begin
            qrs_n = 1'b0;
            case (state_r)
                ST_LEARN: begin
                    if (peak_flag && (p_s > max_pk_r)) begin
                        max_pk_n = p_s;
                    end else begin
                        max_pk_n = max_pk_r;
                    end
                    if (learn_cnt_r == LCW'(LEARN_LEN - 1)) begin
                        state_n     = ST_DETECT;
                        spki_n      = max_pk_n;
                        npki_n      = max_pk_n >>> 3;
                        learn_cnt_n = {LCW{1'b0}};
                    end else begin
                        learn_cnt_n = learn_cnt_r + {{(LCW-1){1'b0}}, 1'b1};
                    end
                end
                ST_DETECT: begin
                    rr_cnt_n = rr_inc_s;
                    if (qrs_det_s) begin
                        spki_n    = spki_upd_s;
                        rr_int_n  = rr_cnt_r;
                        rr_cnt_n  = {RR_WIDTH{1'b0}};
                        ref_cnt_n = RCW'(REFRACTORY - 1);
                        qrs_n     = 1'b1;
                        state_n   = ST_REFRACT;
                    end else if (sb_hit_s) begin
                        spki_n    = sb_spki_s;
                        rr_int_n  = sb_pos_s;
                        rr_cnt_n  = rr_cnt_r - sb_pos_s;
                        ref_cnt_n = RCW'(REFRACTORY - 1);
                        qrs_n     = 1'b1;
                        state_n   = ST_REFRACT;
                    end else if (noise_s) begin
                        npki_n = npki_upd_s;
                    end else begin
                        npki_n = npki_r;
                    end
                end
                ST_REFRACT: begin
                    rr_cnt_n = rr_inc_s;
                    if (ref_cnt_r == {RCW{1'b0}}) begin
                        state_n = ST_DETECT;
                    end else begin
                        ref_cnt_n = ref_cnt_r - {{(RCW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_n = ST_LEARN;
                end
            endcase
            timer_n = (state_n == ST_REFRACT);
        end else begin
            qrs_n = qrs_r;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= ST_LEARN;
            spki_r      <= {LW{1'b0}};
            npki_r      <= {LW{1'b0}};
            max_pk_r    <= {LW{1'b0}};
            learn_cnt_r <= {LCW{1'b0}};
            ref_cnt_r   <= {RCW{1'b0}};
            rr_cnt_r    <= {RR_WIDTH{1'b0}};
            rr_int_r    <= {RR_WIDTH{1'b0}};
            qrs_r       <= 1'b0;
            timer_r     <= 1'b0;
        end else begin
            state_r     <= state_n;
            spki_r      <= spki_n;
            npki_r      <= npki_n;
            max_pk_r    <= max_pk_n;
            learn_cnt_r <= learn_cnt_n;
            ref_cnt_r   <= ref_cnt_n;
            rr_cnt_r    <= rr_cnt_n;
            rr_int_r    <= rr_int_n;
            qrs_r       <= qrs_n;
            timer_r     <= timer_n;
        end
    end

    assign qrs_flag         = qrs_r & en;
    assign timer_activation = timer_r;
    assign rr_interval      = rr_int_r;
    assign threshold1       = thr1_s[DATA_WIDTH-1:0];
endmodule

// File: tb/tb_qrs_decision.sv
// Directed self-checking bench for qrs_decision (LEARN_LEN=8, RR_MISS_LIMIT=50).
module tb_qrs_decision;
    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               en = 1'b0;
    logic signed [15:0] peak_in = 16'sd0;
    logic               peak_flag = 1'b0;
    logic               timer_activation, qrs_flag, sb_flag;
    logic [11:0]        rr_interval;
    logic [15:0]        threshold1;

    int passed = 0;
    int total  = 0;

    qrs_decision #(
        .DATA_WIDTH(16), .LEARN_LEN(8), .REFRACTORY(40), .RR_WIDTH(12), .RR_MISS_LIMIT(50)
    ) dut (
        .clk(clk), .rstn(rstn), .en(en), .peak_in(peak_in), .peak_flag(peak_flag),
        .timer_activation(timer_activation), .qrs_flag(qrs_flag), .sb_flag(sb_flag),
        .rr_interval(rr_interval), .threshold1(threshold1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic en;
        logic flag;
        int   pk;
        logic qrs;
        logic tmr;
        int   thr;
    } vec_t;

    vec_t tv[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else passed++;
    endtask

    task automatic step(input logic e, input logic f, input int pk);
        en        = e;
        peak_flag = f;
        peak_in   = 16'(pk);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_qrs"}, 32'(qrs_flag), 32'd0);
        chk({nm, "_sb"}, 32'(sb_flag), 32'd0);
        chk({nm, "_tmr"}, 32'(timer_activation), 32'd0);
        chk({nm, "_rr"}, 32'(rr_interval), 32'd0);
        chk({nm, "_thr1"}, 32'(threshold1), 32'd0);
    endtask

    initial begin
        int hit;
        logic hit_sb;
        logic [11:0] hit_rr;
        logic [15:0] hit_thr;

        tv[0]  = '{1'b1, 1'b1, 300,  1'b0, 1'b0, 0};
        tv[1]  = '{1'b1, 1'b1, 800,  1'b0, 1'b0, 0};
        tv[2]  = '{1'b1, 1'b1, 500,  1'b0, 1'b0, 0};
        tv[3]  = '{1'b1, 1'b0, 0,    1'b0, 1'b0, 0};
        tv[4]  = '{1'b1, 1'b0, 0,    1'b0, 1'b0, 0};
        tv[5]  = '{1'b1, 1'b0, 0,    1'b0, 1'b0, 0};
        tv[6]  = '{1'b1, 1'b0, 0,    1'b0, 1'b0, 0};
        tv[7]  = '{1'b1, 1'b0, 0,    1'b0, 1'b0, 275};  // SPKI=800 NPKI=100
        tv[8]  = '{1'b1, 1'b1, 200,  1'b0, 1'b0, 284};  // noise: NPKI=113
        tv[9]  = '{1'b0, 1'b1, 600,  1'b0, 1'b0, 284};  // disabled: ignored
        tv[10] = '{1'b1, 1'b1, -500, 1'b0, 1'b0, 274};  // negative noise: NPKI=99

        #12;
        chk_all_zero("reset");
        rstn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            step(tv[i].en, tv[i].flag, tv[i].pk);
            chk($sformatf("vec%0d_qrs", i), 32'(qrs_flag), 32'(tv[i].qrs));
            chk($sformatf("vec%0d_tmr", i), 32'(timer_activation), 32'(tv[i].tmr));
            chk($sformatf("vec%0d_thr1", i), 32'(threshold1), 32'(tv[i].thr));
            chk($sformatf("vec%0d_sb", i), 32'(sb_flag), 32'd0);
        end

        // rr_cnt is 2 here; QRS lands at rr_cnt=180
        for (int i = 0; i < 178; i++) step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 600);
        chk("qrs600_qrs", 32'(qrs_flag), 32'd1);
        chk("qrs600_tmr", 32'(timer_activation), 32'd1);
        chk("qrs600_rr", 32'(rr_interval), 32'd180);
        chk("qrs600_thr1", 32'(threshold1), 32'd268);

        // Refractory window with a 10-cycle enable gap; peaks inside must be ignored
        for (int i = 1; i <= 40; i++) begin
            if (i == 21) begin
                for (int k = 0; k < 10; k++) begin
                    step(1'b0, 1'b1, 900);
                    chk("gap_qrs", 32'(qrs_flag), 32'd0);
                    chk("gap_tmr", 32'(timer_activation), 32'd1);
                end
            end
            step(1'b1, 1'b1, 900);
            chk($sformatf("refr%0d_tmr", i), 32'(timer_activation), 32'(i < 40));
            chk($sformatf("refr%0d_qrs", i), 32'(qrs_flag), 32'd0);
            chk($sformatf("refr%0d_thr1", i), 32'(threshold1), 32'd268);
        end

        step(1'b1, 1'b1, 900);
        chk("qrs900_qrs", 32'(qrs_flag), 32'd1);
        chk("qrs900_rr", 32'(rr_interval), 32'd40);
        chk("qrs900_thr1", 32'(threshold1), 32'd272);
        step(1'b0, 1'b0, 0);
        chk("qrs900_masked", 32'(qrs_flag), 32'd0);
        step(1'b1, 1'b0, 0);
        chk("qrs900_onepulse", 32'(qrs_flag), 32'd0);

        for (int i = 0; i < 5000; i++) step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 2000);
        chk("sat_qrs", 32'(qrs_flag), 32'd1);
        chk("sat_rr", 32'(rr_interval), 32'd4095);
        chk("sat_thr1", 32'(threshold1), 32'd310);

        // Asynchronous reset in the middle of the refractory window
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        rstn = 1'b0;
        #2;
        chk_all_zero("midreset");
        step(1'b1, 1'b0, 0);
        chk_all_zero("midreset_held");
        rstn = 1'b1;

        step(1'b1, 1'b1, 300);
        step(1'b1, 1'b1, 800);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0);
        chk("relearn_thr1", 32'(threshold1), 32'd275);
        chk("relearn_qrs", 32'(qrs_flag), 32'd0);

        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 200);
        chk("sbnoise_qrs", 32'(qrs_flag), 32'd0);
        chk("sbnoise_thr1", 32'(threshold1), 32'd284);

        hit = -1;
        hit_sb = 1'b0;
        hit_rr = 12'd0;
        hit_thr = 16'd0;
        for (int j = 1; j <= 40; j++) begin
            step(1'b1, 1'b0, 0);
            if (qrs_flag && hit < 0) begin
                hit = j;
                hit_sb = sb_flag;
                hit_rr = rr_interval;
                hit_thr = threshold1;
            end
        end
`ifdef QRS_SEARCHBACK_EN
        chk("sb_hit_pos", 32'(hit), 32'd20);
        chk("sb_flag", 32'(hit_sb), 32'd1);
        chk("sb_rr", 32'(hit_rr), 32'd30);
        chk("sb_thr1", 32'(hit_thr), 32'd247);
`else
        chk("nosb_hit", 32'(hit), 32'hFFFF_FFFF);
        chk("nosb_sbflag", 32'(sb_flag), 32'd0);
        chk("nosb_rr", 32'(rr_interval), 32'd0);
        chk("nosb_thr1", 32'(threshold1), 32'd284);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/qrs_decision.md
# qrs_decision

Adaptive-threshold QRS decision stage of the Pan-Tompkins chain. Consumes the peak value/flag pair produced by the peak detector, classifies each peak as signal (QRS) or noise, maintains running SPKI/NPKI estimates and thresholds, and drives the `timer_activation` line back to the peak detector during the refractory window. Also reports the RR interval in samples for downstream rate logic.

## Interface
- `DATA_WIDTH`, 16: width of the peak value and level estimates.
- `LEARN_LEN`, 400: enabled samples in the initial learning phase (2 s at 200 Hz).
- `REFRACTORY`, 40: refractory length in enabled samples (200 ms).
- `RR_WIDTH`, 12: RR counter width.
- `RR_MISS_LIMIT`, 332: searchback trigger in samples (166 % of nominal RR). Used only with searchback.

- `clk` in 1: clock, rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `en` in 1: sample enable; the block advances only when high.
- `peak_in` in DATA_WIDTH, signed: peak value from the peak detector.
- `peak_flag` in 1: `peak_in` holds a new local maximum this sample.
- `timer_activation` out 1: high during the refractory window.
- `qrs_flag` out 1: one-sample pulse on accepted QRS.
- `sb_flag` out 1: one-sample pulse when the QRS came from searchback.
- `rr_interval` out RR_WIDTH: samples between the last two QRS.
- `threshold1` out DATA_WIDTH: current primary threshold THR1.

## Operation
- FSM states:
  - LEARN (reset state)
    - Tracks `max_pk` = largest `peak_in` seen with `peak_flag`.
    - Leaves after LEARN_LEN enabled samples: SPKI <= max_pk, NPKI <= max_pk>>>3, goes to DETECT.
    - No `qrs_flag` is issued in LEARN.
  - DETECT
    - On `peak_flag`: p = max(`peak_in`, 0).
    - If p > THR1: QRS. SPKI <= SPKI - (SPKI>>3) + (p>>3), go to REFRACT.
    - Else: noise. NPKI <= NPKI - (NPKI>>3) + (p>>3).
  - REFRACT
    - Down-counter loaded with REFRACTORY-1, decremented per enabled sample; returns to DETECT at 0.
    - `peak_flag` is ignored (no classification, no estimate update).
- Thresholds are combinational from the registered levels:
  - THR1 = NPKI + ((SPKI - NPKI)>>>2)
  - THR2 = THR1>>1
  - Levels are non-negative and computed in DATA_WIDTH+1 bits. SPKI < NPKI is permitted; THR1 follows the signed formula.
- RR counter `rr_cnt`:
  - Reset 0; increments per enabled sample in DETECT/REFRACT; saturates at all-ones.
  - On QRS: `rr_interval` <= `rr_cnt`, `rr_cnt` <= 0.
  - Saturation holds until the next QRS.
- `en` low: all registers hold, counters freeze. `qrs_flag` and `sb_flag` are combinationally forced 0. `timer_activation` keeps its registered value.

## Timing
- Reset values: state LEARN, SPKI = NPKI = 0, all counters 0; all outputs 0.
- Latency: `peak_flag` sampled at edge N (with `en`). On the same edge:
  - `qrs_flag` asserts and SPKI/NPKI update.
  - `threshold1` reflects the new levels from edge N.
- `qrs_flag` lasts exactly one enabled sample.
- `timer_activation` rises on the same edge as `qrs_flag` and stays high for exactly REFRACTORY enabled samples.
- `peak_flag` on the edge where REFRACT exits: ignored.
- Reset mid-operation: returns to LEARN immediately; all estimates are lost.

## Configuration
- Macro: `QRS_SEARCHBACK_EN`.
- With the macro defined:
  - In DETECT, the block records the largest noise peak since the last QRS (`sb_pk`) and the `rr_cnt` value at that peak (`sb_pos`).
  - When `rr_cnt` reaches RR_MISS_LIMIT and `sb_pk` > THR2, `sb_pk` is accepted as QRS:
    - `qrs_flag` and `sb_flag` pulse.
    - SPKI <= SPKI - (SPKI>>2) + (sb_pk>>2).
    - `rr_interval` <= `sb_pos`; `rr_cnt` <= `rr_cnt` - `sb_pos`.
    - Goes to REFRACT.
  - If `sb_pk` <= THR2, nothing happens; the condition is re-evaluated each sample.
  - `sb_pk` clears on any QRS.
  - A normal QRS in the same sample takes priority.
- Without the macro: no searchback logic is built, `sb_flag` is tied 0, and RR_MISS_LIMIT is unused.

## Test plan
- LEARN_LEN=8, peaks 300, 800, 500 during learn -> after the 8th sample SPKI=800, NPKI=100, `threshold1`=275, no `qrs_flag`.
- From the above, peak 600 in DETECT -> `qrs_flag` 1 sample, SPKI=775, `timer_activation` high for exactly 40 samples, peaks inside are ignored.
- Noise peak 200 (THR1=275) -> no `qrs_flag`, NPKI=113.
- QRS at `rr_cnt`=180 -> `rr_interval`=180; 5000 samples without QRS -> `rr_cnt` saturates at 4095.
- `QRS_SEARCHBACK_EN`, RR_MISS_LIMIT=50, SPKI=800, NPKI=100, noise peak 200 at `rr_cnt`=30 -> at `rr_cnt`=50 `qrs_flag`/`sb_flag` pulse, `rr_interval`=30, SPKI=650. Repeat without the macro -> no pulse.
- `en` low for 10 cycles mid-REFRACT -> counters frozen, pulses 0; `rstn` low mid-REFRACT -> all outputs 0, state LEARN.
